// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared constants and FSM state type for the binary-to-BCD converter
package bin2bcd_pkg;

  localparam int BIN_W_DEF = 8;
  localparam int DIG_DEF   = 3;
  localparam int CNT_W     = $clog2(BIN_W_DEF);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - start/done conversion handshake between requester and converter
interface bin2bcd_seq_if
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int DIG   = DIG_DEF
);

  logic               start;
  logic [BIN_W-1:0]   bin;
  logic               busy;
  logic               done;
  logic [4*DIG-1:0]   bcd;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd
  );

endinterface

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - one-digit add-3 correction applied before each double-dabble shift
module bcd_add3 (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);

  assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter, one bit per cycle
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int DIG   = DIG_DEF
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  bin2bcd_seq_if.slave  s_if
);

  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BIN_W - 1);

  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [BIN_W-1:0]        r_shift, w_shift_nxt;
  logic [4*DIG-1:0]        r_scr, w_scr_nxt;
  logic [4*DIG-1:0]        r_bcd, w_bcd_nxt;
  logic                    r_done, w_done_nxt;
  logic [4*DIG-1:0]        w_adj;
  logic [4*DIG+BIN_W-1:0]  w_cat;

  for (genvar g = 0; g < DIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_d (r_scr[4*g +: 4]),
      .o_d (w_adj[4*g +: 4])
    );
  end

  // Corrected digits and remaining binary bits shift as one word; the digit
  // MSB falls off the top, which is safe because DIG covers the full range.
  assign w_cat = {w_adj, r_shift} << 1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_scr_nxt   = r_scr;
    w_bcd_nxt   = r_bcd;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_if.start) begin
          w_shift_nxt = s_if.bin;
          w_scr_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_scr_nxt   = w_cat[4*DIG+BIN_W-1 : BIN_W];
        w_shift_nxt = w_cat[BIN_W-1:0];
        w_cnt_nxt   = r_cnt + 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_bcd_nxt   = w_cat[4*DIG+BIN_W-1 : BIN_W];
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_scr   <= '0;
      r_bcd   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_scr   <= w_scr_nxt;
      r_bcd   <= w_bcd_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign s_if.busy = (r_state == ST_SHIFT);
  assign s_if.done = r_done;
  assign s_if.bcd  = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq against a decimal-arithmetic model
module tb_bin2bcd_seq;

  localparam int BW = 8;
  localparam int DG = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(BW), .DIG(DG)) bus ();

  bin2bcd_seq #(.BIN_W(BW), .DIG(DG)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .s_if      (bus)
  );

  int n_checks = 0;
  int n_err = 0;
  logic [11:0] exp_bcd = '0;

  function automatic logic [11:0] ref_bcd(input int v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.bin = '0;
    tick();
    tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, want 0", bus.busy); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, want 0", bus.done); end
    n_checks++;
    if (bus.bcd !== 12'h000) begin n_err++; $display("FAIL reset_bcd: got %h, want 000", bus.bcd); end
    exp_bcd = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single(input int v);
    bus.bin = 8'(v);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.bin = 8'($urandom);
    for (int c = 1; c <= BW; c++) begin
      n_checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.bcd !== exp_bcd) begin
        n_err++;
        $display("FAIL single_busy v=%0d cyc=%0d: busy=%b done=%b bcd=%h, want busy=1 done=0 bcd=%h",
                 v, c, bus.busy, bus.done, bus.bcd, exp_bcd);
      end
      tick();
    end
    exp_bcd = ref_bcd(v);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.bcd !== exp_bcd) begin
      n_err++;
      $display("FAIL single_done v=%0d: busy=%b done=%b bcd=%h, want busy=0 done=1 bcd=%h",
               v, bus.busy, bus.done, bus.bcd, exp_bcd);
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.bcd !== exp_bcd) begin
      n_err++;
      $display("FAIL single_after v=%0d: busy=%b done=%b bcd=%h, want busy=0 done=0 bcd=%h",
               v, bus.busy, bus.done, bus.bcd, exp_bcd);
    end
  endtask

  task automatic test_ignore_start;
    bus.bin = 8'd200;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= BW; c++) begin
      n_checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL ignore_busy cyc=%0d: busy=%b done=%b, want busy=1 done=0", c, bus.busy, bus.done);
      end
      if (c == 4) begin
        bus.start = 1'b1;
        bus.bin = 8'd77;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    exp_bcd = ref_bcd(200);
    n_checks++;
    if (bus.done !== 1'b1 || bus.bcd !== exp_bcd) begin
      n_err++;
      $display("FAIL ignore_done: done=%b bcd=%h, want done=1 bcd=%h", bus.done, bus.bcd, exp_bcd);
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.bcd !== exp_bcd) begin
        n_err++;
        $display("FAIL ignore_extra cyc=%0d: busy=%b done=%b bcd=%h, want busy=0 done=0 bcd=%h",
                 c, bus.busy, bus.done, bus.bcd, exp_bcd);
      end
    end
  endtask

  task automatic test_reset_mid;
    bus.bin = 8'd150;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    exp_bcd = '0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd !== 12'h000) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b bcd=%h, want busy=0 done=0 bcd=000",
               bus.busy, bus.done, bus.bcd);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: busy=%b done=%b, want busy=0 done=0", bus.busy, bus.done);
    end
    test_single(42);
  endtask

  task automatic test_back_to_back(input int first, input int count);
    bus.bin = 8'(first);
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < count; i++) begin
      bus.bin = 8'(first + i + 1);
      for (int c = 1; c <= BW; c++) begin
        n_checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.bcd !== exp_bcd) begin
          n_err++;
          $display("FAIL b2b_busy v=%0d cyc=%0d: busy=%b done=%b bcd=%h, want busy=1 done=0 bcd=%h",
                   first + i, c, bus.busy, bus.done, bus.bcd, exp_bcd);
        end
        tick();
      end
      exp_bcd = ref_bcd(first + i);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.bcd !== exp_bcd) begin
        n_err++;
        $display("FAIL b2b_done v=%0d: busy=%b done=%b bcd=%h, want busy=0 done=1 bcd=%h",
                 first + i, bus.busy, bus.done, bus.bcd, exp_bcd);
      end
      if (i == count - 1) bus.start = 1'b0;
      tick();
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd !== exp_bcd) begin
      n_err++;
      $display("FAIL b2b_end: busy=%b done=%b bcd=%h, want busy=0 done=0 bcd=%h",
               bus.busy, bus.done, bus.bcd, exp_bcd);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      int v;
      int gap;
      v = int'($urandom_range(0, 255));
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        bus.bin = 8'($urandom);
        tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd !== exp_bcd) begin
          n_err++;
          $display("FAIL rand_idle n=%0d: busy=%b done=%b bcd=%h, want busy=0 done=0 bcd=%h",
                   n, bus.busy, bus.done, bus.bcd, exp_bcd);
        end
      end
      bus.bin = 8'(v);
      bus.start = 1'b1;
      tick();
      for (int c = 1; c <= BW; c++) begin
        n_checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.bcd !== exp_bcd) begin
          n_err++;
          $display("FAIL rand_busy v=%0d cyc=%0d: busy=%b done=%b bcd=%h, want busy=1 done=0 bcd=%h",
                   v, c, bus.busy, bus.done, bus.bcd, exp_bcd);
        end
        bus.start = 1'($urandom);
        bus.bin = 8'($urandom);
        if (c == BW) bus.start = 1'b0;
        tick();
      end
      exp_bcd = ref_bcd(v);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.bcd !== exp_bcd) begin
        n_err++;
        $display("FAIL rand_done v=%0d: busy=%b done=%b bcd=%h, want busy=0 done=1 bcd=%h",
                 v, bus.busy, bus.done, bus.bcd, exp_bcd);
      end
      tick();
      n_checks++;
      if (bus.done !== 1'b0 || bus.bcd !== exp_bcd) begin
        n_err++;
        $display("FAIL rand_pulse v=%0d: done=%b bcd=%h, want done=0 bcd=%h", v, bus.done, bus.bcd, exp_bcd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(255);
    test_single(0);
    test_single(9);
    test_single(10);
    test_single(100);
    test_back_to_back(1, 3);
    test_ignore_start();
    test_reset_mid();
    test_back_to_back(0, 256);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
